// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO deserializer.
package sipo_pkg;

    // Receive FSM: waiting for a frame start, or collecting the remaining bits
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_e;

    // Bit counter width; a one-bit counter is the floor so tiny words still elaborate
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_hold_slot.sv
// One-entry valid/ready holding register for assembled words.
module sipo_hold_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             accept
);

    // The slot can take a new word when empty or when its current word leaves this cycle
    assign accept = !valid || ready;

    // Load wins over drain so back-to-back words keep valid high; otherwise a transfer empties the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && accept) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: frames WIDTH qualified bits after a sync
// pulse and hands each word to a valid/ready consumer through a holding slot.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_valid,
    input  logic             ser_in,
    input  logic             sync,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("sipo_deser: WIDTH must be at least 2");
    end

    sipo_state_e      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] part;
    logic [WIDTH-2:0] base;
    logic [WIDTH-2:0] next_part;
    logic [WIDTH-1:0] full;
    logic [WIDTH-1:0] word_q;
    logic             done_q;
    logic             restart;
    logic             slot_accept;

    // A sync bit (or any frame start from IDLE) begins from an empty partial word
    assign restart = (state == IDLE) || sync;

    // Merge the incoming bit into the partial word in the configured direction
    always_comb begin
        base      = restart ? '0 : part;
        full      = '0;
        next_part = '0;
        if (MSB_FIRST) begin
            full      = {base, ser_in};
            next_part = full[WIDTH-2:0];
        end else begin
            full      = {ser_in, base};
            next_part = full[WIDTH-1:1];
        end
    end

    // Frame FSM, bit counter and partial word; a completed word is staged one cycle before the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            part      <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ser_valid && sync) begin
                        part  <= next_part;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_valid) begin
                        if (sync) begin
                            part      <= next_part;
                            cnt       <= CW'(1);
                            frame_err <= 1'b1;
                        end else if (cnt == LAST_CNT) begin
                            word_q <= full;
                            done_q <= 1'b1;
                            part   <= '0;
                            cnt    <= '0;
                            state  <= IDLE;
                        end else begin
                            part <= next_part;
                            cnt  <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == SHIFT);

    // Sticky overrun when a staged word finds the slot full and not draining; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end else if (done_q && !slot_accept) begin
            overrun <= 1'b1;
        end
    end

    sipo_hold_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (done_q),
        .load_data (word_q),
        .ready     (out_ready),
        .data      (data_out),
        .valid     (out_valid),
        .accept    (slot_accept)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed, table-driven bench for sipo_deser (WIDTH=4, MSB first).
module tb_sipo_deser;

    logic       clk;
    logic       rst;
    logic       ser_valid;
    logic       ser_in;
    logic       sync;
    logic [3:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;
    logic       frame_err;
    logic       clr_err;

    int vectors;
    int miscompares;

    typedef struct {
        logic       sv;
        logic       si;
        logic       sy;
        logic       rdy;
        logic       clr;
        logic [3:0] d;
        logic       v;
        logic       b;
        logic       o;
        logic       f;
    } vec_t;

    vec_t vecs[$];

    sipo_deser #(
        .WIDTH(4),
        .MSB_FIRST(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_valid (ser_valid),
        .ser_in    (ser_in),
        .sync      (sync),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic sv, input logic si, input logic sy,
                                input logic rdy, input logic clr, input logic [3:0] d,
                                input logic v, input logic b, input logic o, input logic f);
        vec_t r;
        r.sv = sv; r.si = si; r.sy = sy; r.rdy = rdy; r.clr = clr;
        r.d = d; r.v = v; r.b = b; r.o = o; r.f = f;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t x);
        ser_valid = x.sv;
        ser_in    = x.si;
        sync      = x.sy;
        out_ready = x.rdy;
        clr_err   = x.clr;
    endtask

    task automatic checkOutput(input string tag, input vec_t x);
        vectors++;
        if (data_out !== x.d || out_valid !== x.v || busy !== x.b ||
            overrun !== x.o || frame_err !== x.f) begin
            miscompares++;
            $display("[TB] FAIL %s: got data=%h valid=%b busy=%b overrun=%b frame_err=%b, want data=%h valid=%b busy=%b overrun=%b frame_err=%b",
                     tag, data_out, out_valid, busy, overrun, frame_err,
                     x.d, x.v, x.b, x.o, x.f);
        end
    endtask

    task automatic runVec(input string tag, input vec_t x);
        applyStimulus(x);
        @(posedge clk);
        #1;
        checkOutput(tag, x);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));

        // sv si sy rdy clr | data valid busy ovr ferr  (outputs after the edge)
        // Basic 4'hB, consumer ready
        vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'h0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'hB, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'hB, 0, 0, 0, 0));
        // 4'h6 with gaps between bits
        vecs.push_back(mk(1, 0, 1, 1, 0, 4'hB, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'hB, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'hB, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'hB, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'hB, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'hB, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h6, 0, 0, 0, 0));
        // Backpressure: 4'hB held, 4'h5 dropped, then clear
        vecs.push_back(mk(1, 1, 1, 0, 0, 4'h6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'h6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'h6, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'h6, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'hB, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'hB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'hB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'hB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'hB, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'hB, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'hB, 1, 0, 0, 0));
        // Drain on completion: 4'h5 loads as 4'hB leaves
        vecs.push_back(mk(1, 0, 1, 0, 0, 4'hB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'hB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'hB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 4'hB, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h5, 0, 0, 0, 0));
        // Resync mid-frame: sync,1,1 then sync+0,1,0,1
        vecs.push_back(mk(1, 1, 1, 1, 0, 4'h5, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'h5, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 4'h5, 0, 1, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'h5, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h5, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'h5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h5, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 4'h5, 0, 0, 0, 0));
        // Unsynced bits in IDLE are ignored
        vecs.push_back(mk(1, 1, 0, 1, 0, 4'h5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 4'h5, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_state", mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            runVec($sformatf("vec[%0d]", i), vecs[i]);
        end

        // Reset mid-frame with a word held: load 4'hA, start a frame, then reset
        runVec("rst_a1", mk(1, 1, 1, 0, 0, 4'h5, 0, 1, 0, 0));
        runVec("rst_a2", mk(1, 0, 0, 0, 0, 4'h5, 0, 1, 0, 0));
        runVec("rst_a3", mk(1, 1, 0, 0, 0, 4'h5, 0, 1, 0, 0));
        runVec("rst_a4", mk(1, 0, 0, 0, 0, 4'h5, 0, 0, 0, 0));
        runVec("rst_held", mk(0, 0, 0, 0, 0, 4'hA, 1, 0, 0, 0));
        runVec("rst_p1", mk(1, 1, 1, 0, 0, 4'hA, 1, 1, 0, 0));
        runVec("rst_p2", mk(1, 0, 0, 0, 0, 4'hA, 1, 1, 0, 0));
        applyStimulus(mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        rst = 1'b1;
        #2;
        checkOutput("rst_async", mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        checkOutput("rst_held_edge", mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        rst = 1'b0;
        // Fresh frame 4'h9 is the only word emitted
        runVec("post_b1", mk(1, 1, 1, 0, 0, 4'h0, 0, 1, 0, 0));
        runVec("post_b2", mk(1, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0));
        runVec("post_b3", mk(1, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0));
        runVec("post_b4", mk(1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0));
        runVec("post_word", mk(0, 0, 0, 0, 0, 4'h9, 1, 0, 0, 0));

        // clr_err in the same cycle as a drop keeps overrun low
        runVec("clr_b1", mk(1, 0, 1, 0, 0, 4'h9, 1, 1, 0, 0));
        runVec("clr_b2", mk(1, 0, 0, 0, 0, 4'h9, 1, 1, 0, 0));
        runVec("clr_b3", mk(1, 1, 0, 0, 0, 4'h9, 1, 1, 0, 0));
        runVec("clr_b4", mk(1, 1, 0, 0, 0, 4'h9, 1, 0, 0, 0));
        runVec("clr_wins", mk(0, 0, 0, 0, 1, 4'h9, 1, 0, 0, 0));
        runVec("clr_after", mk(0, 0, 0, 0, 0, 4'h9, 1, 0, 0, 0));
        runVec("final_drain", mk(0, 0, 0, 1, 0, 4'h9, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
